keypad_entry_buffer: RTL and testbench



---
 rtl/keypad_pkg.sv | 24 ++
 rtl/key_event_debounce.sv | 78 +++++++
 rtl/keypad_entry_buffer.sv | 152 +++++++++++++++
 tb/tb_keypad_entry_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad entry path: function key codes, the
// one-hot encoding of the entry state machine and a digit classifier.
// -----------------------------------------------------------------------------
package keypad_pkg;

    // Function keys on the 4x4 pad; B, C and D are deliberately unassigned.
    localparam logic [3:0] KEY_BKSP = 4'hA;
    localparam logic [3:0] KEY_CLR  = 4'hE;
    localparam logic [3:0] KEY_ENT  = 4'hF;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'b001,
        ST_ENTRY = 3'b010,
        ST_DONE  = 3'b100
    } entry_state_e;

    // Codes 0..9 are decimal digits.
    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/key_event_debounce.sv
// -----------------------------------------------------------------------------
// key_event_debounce
// Synchronizes the scanner's key_down/key_val into clk, debounces key_down and
// emits exactly one event per press.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   key_down     scanner key-pressed level (asynchronous)
//   key_val      scanner key code (asynchronous, valid while key_down held)
//   evt_pulse    high for the single cycle in which a press is accepted
//   evt_code     code of the accepted key (valid with evt_pulse)
// -----------------------------------------------------------------------------
module key_event_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_down,
    input  logic [3:0] key_val,
    output logic       evt_pulse,
    output logic [3:0] evt_code
);

    localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    // cnt reaches this value once the synced level has been seen for
    // DEBOUNCE_CYC consecutive cycles (the change cycle itself plus
    // DEBOUNCE_CYC-1 matching comparisons).
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYC - 2);

    logic       kd_s1, kd_s2, kd_last;
    logic [3:0] kv_s1, kv_s2;
    logic [CNT_W-1:0] cnt_q;
    logic       armed_q;
    logic [3:0] code_q;
    logic       stable;

    assign stable    = (kd_s2 == kd_last) && (cnt_q == CNT_DONE);
    assign evt_pulse = stable && kd_s2 && !armed_q;
    // The code is handed over in the acceptance cycle; the latch keeps it
    // afterwards for as long as the key stays armed.
    assign evt_code  = evt_pulse ? kv_s2 : code_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kd_s1   <= 1'b0;
            kd_s2   <= 1'b0;
            kv_s1   <= 4'h0;
            kv_s2   <= 4'h0;
            kd_last <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            code_q  <= 4'h0;
        end else begin
            kd_s1   <= key_down;
            kd_s2   <= kd_s1;
            kv_s1   <= key_val;
            kv_s2   <= kv_s1;
            kd_last <= kd_s2;

            // Any edge on the synced level restarts the stability window.
            if (kd_s2 != kd_last) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_DONE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (evt_pulse) begin
                armed_q <= 1'b1;
                code_q  <= kv_s2;
            end else if (stable && !kd_s2) begin
                armed_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/keypad_entry_buffer.sv
// -----------------------------------------------------------------------------
// keypad_entry_buffer
// Turns debounced keypad presses into a multi-digit BCD entry with backspace,
// clear and enter, and publishes committed values with a one-cycle strobe.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   key_down      scanner key-pressed level (asynchronous)
//   key_val       scanner key code: 0-9 digits, A bksp, E clear, F enter
//   entry_bcd     in-progress digits, digit 0 (latest) in bits [3:0]
//   entry_len     number of digits entered
//   commit_bcd    last committed value
//   commit_len    digit count of the committed value
//   commit_valid  one-cycle pulse when commit_bcd/commit_len update
//   key_evt       one-cycle pulse per accepted key press
//   err           one-cycle pulse on a rejected key
// -----------------------------------------------------------------------------
module keypad_entry_buffer
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS   = 4,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int LEN_W        = $clog2(MAX_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_down,
    input  logic [3:0]              key_val,
    output logic [4*MAX_DIGITS-1:0] entry_bcd,
    output logic [LEN_W-1:0]        entry_len,
    output logic [4*MAX_DIGITS-1:0] commit_bcd,
    output logic [LEN_W-1:0]        commit_len,
    output logic                    commit_valid,
    output logic                    key_evt,
    output logic                    err
);

    localparam int BUF_W = 4 * MAX_DIGITS;
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(MAX_DIGITS);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    logic       evt_pulse;
    logic [3:0] evt_code;

    key_event_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_down  (key_down),
        .key_val   (key_val),
        .evt_pulse (evt_pulse),
        .evt_code  (evt_code)
    );

    entry_state_e     state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [BUF_W-1:0] commit_bcd_q, commit_bcd_d;
    logic [LEN_W-1:0] commit_len_q, commit_len_d;
    logic             commit_valid_q, commit_valid_d;
    logic             err_q, err_d;
    logic             key_evt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_EMPTY;
            buf_q          <= '0;
            len_q          <= '0;
            commit_bcd_q   <= '0;
            commit_len_q   <= '0;
            commit_valid_q <= 1'b0;
            err_q          <= 1'b0;
            key_evt_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            len_q          <= len_d;
            commit_bcd_q   <= commit_bcd_d;
            commit_len_q   <= commit_len_d;
            commit_valid_q <= commit_valid_d;
            err_q          <= err_d;
            key_evt_q      <= evt_pulse;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        buf_d          = buf_q;
        len_d          = len_q;
        commit_bcd_d   = commit_bcd_q;
        commit_len_d   = commit_len_q;
        commit_valid_d = 1'b0;
        err_d          = 1'b0;

        if (evt_pulse) begin
            if (is_digit(evt_code)) begin
                if (state_q == ST_ENTRY) begin
                    if (len_q == LEN_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        buf_d = {buf_q[BUF_W-5:0], evt_code};
                        len_d = len_q + LEN_ONE;
                    end
                end else begin
                    // From EMPTY or DONE the digit starts a fresh entry.
                    buf_d   = {{(BUF_W-4){1'b0}}, evt_code};
                    len_d   = LEN_ONE;
                    state_d = ST_ENTRY;
                end
            end else if (evt_code == KEY_BKSP) begin
                if (state_q == ST_ENTRY) begin
                    buf_d = {4'h0, buf_q[BUF_W-1:4]};
                    len_d = len_q - LEN_ONE;
                    if (len_q == LEN_ONE) begin
                        state_d = ST_EMPTY;
                    end
                end else if (state_q == ST_DONE) begin
                    buf_d   = '0;
                    len_d   = '0;
                    state_d = ST_EMPTY;
                end
            end else if (evt_code == KEY_CLR) begin
                buf_d   = '0;
                len_d   = '0;
                state_d = ST_EMPTY;
            end else if (evt_code == KEY_ENT) begin
                if (state_q == ST_EMPTY) begin
                    err_d = 1'b1;
                end else begin
                    commit_bcd_d   = buf_q;
                    commit_len_d   = len_q;
                    commit_valid_d = 1'b1;
                    state_d        = ST_DONE;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign entry_bcd    = buf_q;
    assign entry_len    = len_q;
    assign commit_bcd   = commit_bcd_q;
    assign commit_len   = commit_len_q;
    assign commit_valid = commit_valid_q;
    assign key_evt      = key_evt_q;
    assign err          = err_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// -----------------------------------------------------------------------------
// tb_keypad_entry_buffer
// Directed key sequences against keypad_entry_buffer (MAX_DIGITS = 4,
// DEBOUNCE_CYC = 4). A digit-list model of the entry and committed value is
// advanced on each key event and compared with the DUT every cycle; literal
// expectations pin the model at the end of each scenario.
// -----------------------------------------------------------------------------
module tb_keypad_entry_buffer;

    localparam int MAX_DIGITS = 4;
    localparam int DEB        = 4;
    localparam int LEN_W      = 3;
    localparam int BUF_W      = 4 * MAX_DIGITS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_down = 1'b0;
    logic [3:0]       key_val = 4'h0;
    logic [BUF_W-1:0] entry_bcd, commit_bcd;
    logic [LEN_W-1:0] entry_len, commit_len;
    logic             commit_valid, key_evt, err;

    keypad_entry_buffer #(
        .MAX_DIGITS   (MAX_DIGITS),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_down     (key_down),
        .key_val      (key_val),
        .entry_bcd    (entry_bcd),
        .entry_len    (entry_len),
        .commit_bcd   (commit_bcd),
        .commit_len   (commit_len),
        .commit_valid (commit_valid),
        .key_evt      (key_evt),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int evt_count = 0;
    int cv_count = 0;
    int err_count = 0;
    logic [3:0] cur_code = 4'h0;

    // Model: entered digits in entry order (oldest first), committed digits,
    // whether the last action was a commit, and this cycle's expected pulses.
    int m_digs[$];
    int m_commit[$];
    bit m_done = 1'b0;
    bit m_err = 1'b0;
    bit m_cv = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bcd_of(input int q[$]);
        logic [15:0] v = '0;
        foreach (q[i]) v = {v[11:0], 4'(q[i])};
        return v;
    endfunction

    task automatic model_apply(input logic [3:0] c);
        m_err = 1'b0;
        m_cv  = 1'b0;
        if (c <= 4'd9) begin
            if (m_done) begin
                m_digs.delete();
                m_digs.push_back(int'(c));
                m_done = 1'b0;
            end else if (m_digs.size() < MAX_DIGITS) begin
                m_digs.push_back(int'(c));
            end else begin
                m_err = 1'b1;
            end
        end else if (c == 4'hA) begin
            if (m_done) begin
                m_digs.delete();
                m_done = 1'b0;
            end else if (m_digs.size() > 0) begin
                void'(m_digs.pop_back());
            end
        end else if (c == 4'hE) begin
            m_digs.delete();
            m_done = 1'b0;
        end else if (c == 4'hF) begin
            if (m_digs.size() == 0) begin
                m_err = 1'b1;
            end else begin
                m_commit = m_digs;
                m_cv     = 1'b1;
                m_done   = 1'b1;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_digs.delete();
            m_commit.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
            m_cv   = 1'b0;
        end else if (key_evt) begin
            evt_count++;
            model_apply(cur_code);
        end else begin
            m_err = 1'b0;
            m_cv  = 1'b0;
        end
        if (commit_valid) cv_count++;
        if (err) err_count++;
        check("cycle", {entry_bcd, entry_len, commit_bcd, commit_len, commit_valid, err},
              {bcd_of(m_digs), LEN_W'(m_digs.size()), bcd_of(m_commit),
               LEN_W'(m_commit.size()), m_cv, m_err});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [3:0] code);
        int start;
        int waited;
        start    = evt_count;
        key_val  = code;
        cur_code = code;
        key_down = 1'b1;
        waited   = 0;
        while (evt_count == start && waited < 40) begin
            tick(1);
            waited++;
        end
        check("press_evt", 64'(evt_count - start), 64'd1);
        tick(4);
        key_down = 1'b0;
        tick(DEB + 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, c0, r0;

        tick(3);
        rst_n = 1'b1;
        tick(DEB + 6);
        check("idle_after_reset",
              {entry_bcd, entry_len, commit_bcd, commit_len, commit_valid, err, key_evt}, 64'd0);

        // Reset mid-entry.
        press(4'h1);
        press(4'h2);
        check("pre_reset_entry", entry_bcd, 64'h0012);
        rst_n = 1'b0;
        #1;
        check("reset_async_outputs",
              {entry_bcd, entry_len, commit_bcd, commit_len, commit_valid, err, key_evt}, 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(DEB + 6);
        press(4'h5);
        check("after_reset_bcd", entry_bcd, 64'h0005);
        check("after_reset_len", entry_len, 64'd1);

        // Full entry and commit.
        press(4'hE);
        e0 = evt_count;
        c0 = cv_count;
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        press(4'hF);
        check("commit_entry_bcd", entry_bcd, 64'h1234);
        check("commit_bcd", commit_bcd, 64'h1234);
        check("commit_len", commit_len, 64'd4);
        check("commit_pulses", 64'(cv_count - c0), 64'd1);
        check("commit_evts", 64'(evt_count - e0), 64'd5);

        // Bouncing key_down, then a long hold.
        e0 = evt_count;
        key_val  = 4'h7;
        cur_code = 4'h7;
        for (int i = 0; i < 10; i++) begin
            key_down = ~key_down;
            tick(2);
        end
        check("bounce_no_evt", 64'(evt_count - e0), 64'd0);
        key_down = 1'b1;
        for (int i = 0; i < 40 && evt_count == e0; i++) tick(1);
        tick(10000);
        check("bounce_one_evt", 64'(evt_count - e0), 64'd1);
        check("bounce_bcd", entry_bcd, 64'h0007);
        key_down = 1'b0;
        tick(DEB + 8);

        // Overflow, backspace, clear.
        press(4'hE);
        press(4'h9);
        press(4'h8);
        press(4'h7);
        press(4'h6);
        r0 = err_count;
        press(4'h5);
        check("overflow_err", 64'(err_count - r0), 64'd1);
        check("overflow_bcd", entry_bcd, 64'h9876);
        press(4'hA);
        check("bksp_bcd", entry_bcd, 64'h0987);
        check("bksp_len", entry_len, 64'd3);
        press(4'hE);
        check("clear_bcd_len", {entry_bcd, entry_len}, 64'd0);

        // Enter while empty, invalid key.
        r0 = err_count;
        c0 = cv_count;
        press(4'hF);
        check("empty_enter_err", 64'(err_count - r0), 64'd1);
        check("empty_enter_no_commit", 64'(cv_count - c0), 64'd0);
        r0 = err_count;
        e0 = evt_count;
        press(4'hB);
        check("invalid_err", 64'(err_count - r0), 64'd1);
        check("invalid_evt", 64'(evt_count - e0), 64'd1);
        check("invalid_buf", {entry_bcd, entry_len}, 64'd0);

        // Fresh digit after a commit, then recommit.
        press(4'h4);
        press(4'h2);
        press(4'hF);
        check("commit42", commit_bcd, 64'h0042);
        press(4'h3);
        check("after_done_bcd", entry_bcd, 64'h0003);
        check("after_done_len", entry_len, 64'd1);
        check("after_done_commit", commit_bcd, 64'h0042);
        c0 = cv_count;
        press(4'hF);
        press(4'hF);
        check("recommit_pulses", 64'(cv_count - c0), 64'd2);
        check("recommit_bcd", commit_bcd, 64'h0003);
        check("recommit_len", commit_len, 64'd1);

        // Backspace out of DONE, backspace in EMPTY, backspace to empty.
        r0 = err_count;
        press(4'hA);
        check("done_bksp", {entry_bcd, entry_len}, 64'd0);
        press(4'hA);
        check("empty_bksp_no_err", 64'(err_count - r0), 64'd0);
        press(4'h8);
        press(4'hA);
        check("bksp_to_empty", {entry_bcd, entry_len}, 64'd0);
        r0 = err_count;
        press(4'hF);
        check("bksp_empty_enter_err", 64'(err_count - r0), 64'd1);
        check("final_commit_held", commit_bcd, 64'h0003);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
